// File: rtl/ir_smpl_sched.sv
// IR sample scheduler: time-shares one A2D port between left/right IR, derives open flags, IR_Dtrm, en_fusion.
// Latency: outputs and smpl_vld appear 1 cycle after the right-channel ack; a round starts every PERIOD cycles.
// Backpressure: a2d_req held until ack (IR_TIMEOUT_EN adds a watchdog that aborts the round and sets a2d_err).
module ir_smpl_sched #(
  parameter logic [15:0] PERIOD     = 16'd4096,
  parameter logic [2:0]  LFT_CHNL   = 3'd0,
  parameter logic [2:0]  RGHT_CHNL  = 3'd1,
  parameter logic [11:0] OPN_THRESH = 12'h300,
  parameter logic [11:0] HYST       = 12'h040,
  parameter logic [15:0] TIMEOUT    = 16'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              a2d_req,
  output logic [2:0]        a2d_chnl,
  input  logic              a2d_ack,
  input  logic [11:0]       a2d_data,
  output logic [11:0]       lft_IR,
  output logic [11:0]       rght_IR,
  output logic              lft_opn,
  output logic              rght_opn,
  output logic signed [8:0] IR_Dtrm,
  output logic              en_fusion,
  output logic              smpl_vld,
  output logic              a2d_err
);

  typedef enum logic [1:0] {IDLE, REQ_L, REQ_R, UPDT} state_t;

  state_t             state, nxt_state;
  logic [15:0]        timer;
  logic               wrap;
  logic               to_hit;
  logic [11:0]        lft_tmp;
  logic signed [12:0] prev_diff;
  logic               prev_vld;
  logic               upd;
  logic signed [12:0] diff;
  logic signed [13:0] d;
  logic signed [8:0]  d_sat;
  logic               lft_opn_nxt, rght_opn_nxt;
  logic [12:0]        clr_lvl;

  assign wrap = en && (timer == PERIOD - 16'd1);

  always_ff @(posedge clk) begin
    if (rst || !en || wrap) timer <= 16'd0;
    else                    timer <= timer + 16'd1;
  end

`ifdef IR_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (to_cnt == TIMEOUT - 16'd1) && !a2d_ack;

  // Restarts on every state change so each channel request gets the full window.
  always_ff @(posedge clk) begin
    if (rst || (nxt_state != state))              to_cnt <= 16'd0;
    else if ((state == REQ_L) || (state == REQ_R)) to_cnt <= to_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) a2d_err <= 1'b0;
    else if (to_hit && ((state == REQ_L) || (state == REQ_R))) a2d_err <= 1'b1;
  end
`else
  assign to_hit  = 1'b0;
  assign a2d_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    a2d_req   = 1'b0;
    a2d_chnl  = 3'd0;
    smpl_vld  = 1'b0;
    case (state)
      IDLE: if (wrap) nxt_state = REQ_L;
      REQ_L: begin
        a2d_req  = 1'b1;
        a2d_chnl = LFT_CHNL;
        if (a2d_ack)     nxt_state = REQ_R;
        else if (to_hit) nxt_state = IDLE;
      end
      REQ_R: begin
        a2d_req  = 1'b1;
        a2d_chnl = RGHT_CHNL;
        if (a2d_ack)     nxt_state = UPDT;
        else if (to_hit) nxt_state = IDLE;
      end
      UPDT: begin
        smpl_vld  = 1'b1;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Right reading is consumed straight off the bus so results land as UPDT begins.
  assign upd     = (state == REQ_R) && a2d_ack;
  assign diff    = $signed({1'b0, lft_tmp}) - $signed({1'b0, a2d_data});
  assign d       = {diff[12], diff} - {prev_diff[12], prev_diff};
  assign clr_lvl = {1'b0, OPN_THRESH} + {1'b0, HYST};

  always_comb begin
    d_sat = d[8:0];
    if (d > 14'sd255)       d_sat = 9'sd255;
    else if (d < -14'sd256) d_sat = -9'sd256;
  end

  always_comb begin
    lft_opn_nxt = lft_opn;
    if (lft_tmp < OPN_THRESH)              lft_opn_nxt = 1'b1;
    else if ({1'b0, lft_tmp} >= clr_lvl)   lft_opn_nxt = 1'b0;
    rght_opn_nxt = rght_opn;
    if (a2d_data < OPN_THRESH)             rght_opn_nxt = 1'b1;
    else if ({1'b0, a2d_data} >= clr_lvl)  rght_opn_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) lft_tmp <= 12'd0;
    else if ((state == REQ_L) && a2d_ack) lft_tmp <= a2d_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_IR    <= 12'd0;
      rght_IR   <= 12'd0;
      lft_opn   <= 1'b1;
      rght_opn  <= 1'b1;
      IR_Dtrm   <= 9'sd0;
      en_fusion <= 1'b0;
      prev_diff <= 13'sd0;
      prev_vld  <= 1'b0;
    end else if (upd) begin
      lft_IR    <= lft_tmp;
      rght_IR   <= a2d_data;
      lft_opn   <= lft_opn_nxt;
      rght_opn  <= rght_opn_nxt;
      IR_Dtrm   <= prev_vld ? d_sat : 9'sd0;
      en_fusion <= prev_vld & ~(lft_opn_nxt & rght_opn_nxt);
      prev_diff <= diff;
      prev_vld  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_smpl_sched.sv
// Bench for ir_smpl_sched: directed rounds plus randomized rounds against a behavioural model.
module tb_ir_smpl_sched;
  logic              clk = 1'b0;
  logic              rst, en, a2d_ack;
  logic [11:0]       a2d_data;
  logic              a2d_req;
  logic [2:0]        a2d_chnl;
  logic [11:0]       lft_IR, rght_IR;
  logic              lft_opn, rght_opn;
  logic signed [8:0] IR_Dtrm;
  logic              en_fusion, smpl_vld, a2d_err;

  int tests = 0;
  int fails = 0;

  int m_prev_diff, m_dtrm, m_l, m_r;
  bit m_prev_vld, m_lo, m_ro, m_ef, m_err;

  ir_smpl_sched #(.PERIOD(16'd16), .TIMEOUT(16'd64)) dut (
    .clk(clk), .rst(rst), .en(en),
    .a2d_req(a2d_req), .a2d_chnl(a2d_chnl), .a2d_ack(a2d_ack), .a2d_data(a2d_data),
    .lft_IR(lft_IR), .rght_IR(rght_IR), .lft_opn(lft_opn), .rght_opn(rght_opn),
    .IR_Dtrm(IR_Dtrm), .en_fusion(en_fusion), .smpl_vld(smpl_vld), .a2d_err(a2d_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_diff = 0; m_prev_vld = 0; m_lo = 1; m_ro = 1;
    m_l = 0; m_r = 0; m_dtrm = 0; m_ef = 0;
  endtask

  function automatic bit opn_next(input int rd, input bit cur);
    if (rd < 'h300) return 1'b1;
    if (rd >= 'h340) return 1'b0;
    return cur;
  endfunction

  task automatic model_update(input int l, input int r);
    int diff, dd;
    diff = l - r;
    dd = diff - m_prev_diff;
    if (dd > 255) dd = 255;
    if (dd < -256) dd = -256;
    m_dtrm = m_prev_vld ? dd : 0;
    m_lo = opn_next(l, m_lo);
    m_ro = opn_next(r, m_ro);
    m_ef = m_prev_vld && !(m_lo && m_ro);
    m_prev_diff = diff;
    m_prev_vld = 1;
    m_l = l; m_r = r;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_lft_IR"}, lft_IR, m_l);
    chk({tag, "_rght_IR"}, rght_IR, m_r);
    chk({tag, "_lft_opn"}, lft_opn, m_lo);
    chk({tag, "_rght_opn"}, rght_opn, m_ro);
    chk({tag, "_IR_Dtrm"}, IR_Dtrm, m_dtrm);
    chk({tag, "_en_fusion"}, en_fusion, m_ef);
    chk({tag, "_a2d_err"}, a2d_err, m_err);
  endtask

  task automatic wait_req(input int ch);
    int n = 0;
    while (a2d_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", a2d_req, 1);
    chk("req_chnl", a2d_chnl, ch);
  endtask

  task automatic ack(input int data);
    a2d_ack = 1'b1;
    a2d_data = 12'(data);
    @(negedge clk);
    a2d_ack = 1'b0;
    a2d_data = 12'($urandom);
  endtask

  task automatic do_round(input string tag, input int l, input int r, input int dl, input int dr);
    wait_req(0);
    repeat (dl) @(negedge clk);
    ack(l);
    chk({tag, "_chnl_r"}, a2d_chnl, 1);
    chk({tag, "_req_r"}, a2d_req, 1);
    chk({tag, "_no_vld_mid"}, smpl_vld, 0);
    repeat (dr) @(negedge clk);
    ack(r);
    model_update(l, r);
    chk({tag, "_vld"}, smpl_vld, 1);
    chk({tag, "_req_low"}, a2d_req, 0);
    chk_outs(tag);
    @(negedge clk);
    chk({tag, "_vld_pulse"}, smpl_vld, 0);
  endtask

  initial begin
    int n, seen, l, r;
    rst = 1'b1; en = 1'b1; a2d_ack = 1'b0; a2d_data = 12'd0; m_err = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req", a2d_req, 0);
    chk("rst_chnl", a2d_chnl, 0);
    chk("rst_vld", smpl_vld, 0);
    chk_outs("rst");
    rst = 1'b0;

    n = 0;
    while (a2d_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_req_latency", n, 16);

    do_round("r1", 'h970, 'h970, 2, 1);
    chk("r1_dtrm_const", IR_Dtrm, 0);
    chk("r1_ef_const", en_fusion, 0);
    do_round("r2", 'h9A0, 'h970, 0, 3);
    chk("r2_dtrm_const", IR_Dtrm, 48);
    chk("r2_ef_const", en_fusion, 1);
    do_round("r3", 'h970, 'h970, 1, 0);
    chk("r3_dtrm_const", IR_Dtrm, -48);
    do_round("sat_hi", 'h800, 'h000, 0, 0);
    chk("sat_hi_const", IR_Dtrm, 255);
    do_round("sat_lo", 'h000, 'h800, 0, 0);
    chk("sat_lo_const", IR_Dtrm, -256);

    do_round("hy1", 'h2FF, 'h970, 0, 0);
    chk("hy1_const", lft_opn, 1);
    do_round("hy2", 'h320, 'h970, 0, 0);
    chk("hy2_const", lft_opn, 1);
    do_round("hy3", 'h340, 'h970, 0, 0);
    chk("hy3_const", lft_opn, 0);
    do_round("both_opn", 'h100, 'h100, 0, 0);
    chk("both_opn_const", en_fusion, 0);

    ack('hABC);
    chk("idle_ack_vld", smpl_vld, 0);
    chk_outs("idle_ack");

    for (int i = 0; i < 20; i++) begin
      l = ($urandom_range(0, 1) != 0) ? $urandom_range('h2C0, 'h380) : $urandom_range(0, 4095);
      r = ($urandom_range(0, 1) != 0) ? $urandom_range('h2C0, 'h380) : $urandom_range(0, 4095);
      do_round("rand", l, r, $urandom_range(0, 4), $urandom_range(0, 4));
    end

    wait_req(0);
    ack('h456);
    en = 1'b0;
    ack('h654);
    model_update('h456, 'h654);
    chk("en_fall_vld", smpl_vld, 1);
    chk_outs("en_fall");
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (a2d_req === 1'b1) seen = 1;
    end
    chk("en0_no_round", seen, 0);
    en = 1'b1;
    n = 0;
    while (a2d_req !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("en_restart_latency", n, 16);

    wait_req(0);
    ack('h777);
    chk("pre_rst_chnl", a2d_chnl, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("rst_mid_req", a2d_req, 0);
    chk_outs("rst_mid");
    ack('h123);
    chk("late_ack_vld", smpl_vld, 0);
    chk("late_ack_req", a2d_req, 0);
    chk_outs("late_ack");
    do_round("post_rst", 'h500, 'h400, 1, 1);

`ifdef IR_TIMEOUT_EN
    wait_req(0);
    n = 0;
    while (a2d_req === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_len", n, 64);
    m_err = 1;
    chk("timeout_vld", smpl_vld, 0);
    chk_outs("timeout");
    do_round("after_to", 'h600, 'h300, 0, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end
endmodule
